simple_risc_muldiv: RTL and testbench
=====================================

SIMPLE_RISC_MULDIV -- requirements
Module: simple_risc_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 8..64).
REQ-002 SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement operands and 0 = unsigned operands.
REQ-003 SHALL have port Clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning request to begin an operation.
REQ-006 SHALL have port op  input  2  meaning operation select: 00 MUL (low half), 01 DIV, 10 MOD, 11 MULH (high half).
REQ-007 SHALL have ports op1 and op2  input  WIDTH each  meaning dividend/multiplicand and divisor/multiplier.
REQ-008 SHALL have port abort  input  1  meaning cancel the in-flight operation (branch flush).
REQ-009 SHALL have port busy  output  1  meaning an operation is in progress.
REQ-010 SHALL have port done  output  1  meaning a single-cycle pulse marking result valid.
REQ-011 SHALL have port result  output  WIDTH  meaning the last completed result.
REQ-012 SHALL have port div_by_zero  output  1  meaning the last completed DIV/MOD had op2 == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIN.
REQ-014 SHALL in IDLE or FIN accept start=1 at a rising edge, latch op/op1/op2, load cycle counter with WIDTH-1, and enter CALC, except as REQ-020 and REQ-021 state.
REQ-015 SHALL ignore start while in CALC; latched operands SHALL NOT change.
REQ-016 SHALL assert busy in every cycle the state is CALC, and only then.
REQ-017 SHALL perform MUL/MULH as shift-add, one multiplier bit per CALC cycle, on magnitudes when SIGNED=1, with sign correction applied on the 2*WIDTH-bit product at completion.
REQ-018 SHALL perform DIV/MOD as restoring division, one quotient bit per CALC cycle, on magnitudes; quotient truncates toward zero; remainder takes the sign of op1.
REQ-019 SHALL leave CALC for FIN after exactly WIDTH CALC cycles, so accept-edge to done-high latency is WIDTH+1 clock edges.
REQ-020 SHALL, for DIV/MOD with op2 == 0, skip CALC and go directly to FIN on the accept edge, with result = all ones (DIV) or op1 (MOD) and div_by_zero=1.
REQ-021 SHALL, when SIGNED=1, op=DIV, op1 = most-negative and op2 = -1, produce result = most-negative; the MOD equivalent SHALL produce 0; no flag is raised.
REQ-022 SHALL in FIN drive done=1 for exactly one cycle, update result and div_by_zero in that same cycle, then return to IDLE unless a new start is accepted (back-to-back).
REQ-023 SHALL hold result and div_by_zero stable from FIN until the next FIN.
REQ-024 SHALL, on abort=1 at any edge, enter IDLE, clear busy, suppress done, and leave result and div_by_zero unchanged; abort SHALL take priority over simultaneous start.
REQ-025 SHALL set div_by_zero to 0 for every completed MUL/MULH.

Reset
REQ-026 SHALL on reset low, immediately and independent of Clk, force state=IDLE, busy=0, done=0, result=0, div_by_zero=0, and counter=0.
REQ-027 SHALL discard any in-flight operation on reset asserted mid-CALC; no done SHALL follow.
REQ-028 SHALL accept the first start no earlier than the first rising edge after reset deasserts.

Verification
REQ-029 SHALL cover (WIDTH=32, SIGNED=1): MUL op1=-7, op2=6 -> done at edge 33 after accept, result=0xFFFFFFD6, busy high 32 cycles.
REQ-030 SHALL cover DIV -7/2 -> result=0xFFFFFFFD (-3); MOD -7/2 -> result=0xFFFFFFFF (-1); div_by_zero=0.
REQ-031 SHALL cover DIV 5/0 -> done one edge after accept, result=0xFFFFFFFF, div_by_zero=1; MOD 5/0 -> result=5.
REQ-032 SHALL cover DIV 0x80000000/0xFFFFFFFF -> result=0x80000000; MULH 0x7FFFFFFF*0x7FFFFFFF -> result=0x3FFFFFFF.
REQ-033 SHALL cover abort asserted at CALC cycle 10 together with start -> IDLE next edge, no done, result retains previous value; start held during CALC is ignored.
REQ-034 SHALL cover start asserted in the FIN cycle -> second operation accepted with no idle gap, and reset pulsed low mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/simple_risc_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring
// divide, one result bit per cycle, with abort and divide-by-zero.
module simple_risc_muldiv #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MOD  = 2'b10;
    localparam logic [1:0] OP_MULH = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [1:0]       op_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             in_mul;
    logic             in_div;
    logic             accept;
    logic             dz;
    logic             last;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;
    logic [WIDTH:0]   shifted;
    logic             q_bit;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] div_hi_nx;
    logic [WIDTH-1:0] div_lo_nx;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   final_res;

    assign neg_a = (SIGNED != 0) && op1[WIDTH-1];
    assign neg_b = (SIGNED != 0) && op2[WIDTH-1];
    assign mag_a = neg_a ? -op1 : op1;
    assign mag_b = neg_b ? -op2 : op2;

    assign in_mul = (op == OP_MUL) || (op == OP_MULH);
    assign in_div = (op == OP_DIV) || (op == OP_MOD);
    assign accept = (state != CALC) && start && !abort;
    assign dz     = accept && in_div && (op2 == '0);
    assign last   = (cnt_q == '0);

    assign busy = (state == CALC);
    assign done = (state == FIN);

    // Multiply step: conditionally add multiplicand, shift {hi,lo} right.
    assign add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi_nx = add_sum[WIDTH:1];
    assign mul_lo_nx = {add_sum[0], lo_q[WIDTH-1:1]};

    // Divide step: shift in next dividend bit, subtract if it fits.
    assign shifted   = {hi_q, lo_q[WIDTH-1]};
    assign q_bit     = (shifted >= {1'b0, b_q});
    assign diff      = shifted[WIDTH-1:0] - b_q;
    assign div_hi_nx = q_bit ? diff : shifted[WIDTH-1:0];
    assign div_lo_nx = {lo_q[WIDTH-2:0], q_bit};

    assign hi_nx = (op_q[0] == op_q[1]) ? mul_hi_nx : div_hi_nx;
    assign lo_nx = (op_q[0] == op_q[1]) ? mul_lo_nx : div_lo_nx;

    // Sign correction on magnitudes; most-negative / -1 wraps back
    // to most-negative and leaves a zero remainder without a special case.
    assign prod   = {hi_nx, lo_nx};
    assign prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quot_s = (neg_a_q ^ neg_b_q) ? -lo_nx : lo_nx;
    assign rem_s  = neg_a_q ? -hi_nx : hi_nx;

    // Select the completed result half or quotient/remainder.
    always_comb begin
        final_res = '0;
        unique case (1'b1)
            (op_q == OP_MUL):  final_res = prod_s[WIDTH-1:0];
            (op_q == OP_MULH): final_res = prod_s[2*WIDTH-1:WIDTH];
            (op_q == OP_DIV):  final_res = quot_s;
            (op_q == OP_MOD):  final_res = rem_s;
            default:           final_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: abort wins, zero divisor bypasses CALC.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, FIN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (start) begin
                    state_nx = dz ? FIN : CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = FIN;
                end else begin
                    state_nx = CALC;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration registers and result update.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            op_q        <= OP_MUL;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            cnt_q   <= CNT_LOAD;
            hi_q    <= '0;
            lo_q    <= in_mul ? mag_b : mag_a;
            b_q     <= in_mul ? mag_a : mag_b;
            if (dz) begin
                result      <= (op == OP_DIV) ? '1 : op1;
                div_by_zero <= 1'b1;
            end
        end else if (busy && !abort) begin
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q - CW'(1);
            if (last) begin
                result      <= final_res;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simple_risc_muldiv.sv
// Directed bench for simple_risc_muldiv, WIDTH=32 SIGNED=1.
// Inputs driven and outputs sampled on the falling edge.
module tb_simple_risc_muldiv;

    localparam logic [1:0] MUL  = 2'b00;
    localparam logic [1:0] DIV  = 2'b01;
    localparam logic [1:0] MOD  = 2'b10;
    localparam logic [1:0] MULH = 2'b11;

    logic        Clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    simple_risc_muldiv #(.WIDTH(32), .SIGNED(1)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .op1         (op1),
        .op2         (op2),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge Clk);
        op = o; op1 = a; op2 = b; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // lat counts edges from the accept edge (=1) to done observed.
    task automatic wait_done(output int lat, output int bc);
        lat = 1; bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic edz,
                       input int elat);
        int lat, bc;
        start_op(o, a, b);
        wait_done(lat, bc);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 exp 0");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bc, nd;
        logic [31:0] prev;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        op = MUL; op1 = '0; op2 = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;

        // MUL -7*6 with busy-cycle count and one-cycle done
        start_op(MUL, 32'hFFFF_FFF9, 32'd6);
        wait_done(lat, bc);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_busy", 64'(bc), 64'd32);
        chk("mul_res", 64'(result), 64'hFFFF_FFD6);
        chk("mul_dbz", 64'(div_by_zero), 64'd0);
        @(negedge Clk);
        chk("mul_pulse", 64'(done), 64'd0);
        repeat (3) @(negedge Clk);
        chk("mul_hold", 64'(result), 64'hFFFF_FFD6);

        run("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        run("mod_m7_2", MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        run("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        run("mod_5_0", MOD, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 1'b0, 33);
        run("mod_ovf", MOD, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 1'b0, 33);
        run("mulh_max", MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
            32'h3FFF_FFFF, 1'b0, 33);
        run("mulh_neg", MULH, 32'hFFFF_FFF9, 32'd6,
            32'hFFFF_FFFF, 1'b0, 33);
        run("div_100_7", DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run("mod_100_7", MOD, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        run("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
        run("mod_7_m2", MOD, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33);
        run("dz_then", DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        run("mul_clr", MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33);

        // Abort with simultaneous start at CALC cycle 10
        prev = result;
        start_op(MUL, 32'd3, 32'd5);
        repeat (9) @(negedge Clk);
        chk("ab_busy_pre", 64'(busy), 64'd1);
        abort = 1'b1; start = 1'b1; op = DIV; op1 = 32'd8; op2 = 32'd2;
        @(posedge Clk);
        #1;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_done", 64'(done), 64'd0);
        @(negedge Clk);
        abort = 1'b0; start = 1'b0;
        count_done(40, nd);
        chk("ab_nodone", 64'(nd), 64'd0);
        chk("ab_res", 64'(result), 64'(prev));
        chk("ab_idle", 64'(busy), 64'd0);

        // Start held through CALC with changing operands is ignored
        @(negedge Clk);
        op = DIV; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(negedge Clk);
        op = MUL; op1 = 32'd1; op2 = 32'd1;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge Clk);
            lat++;
            op1 = 32'(lat);
        end
        start = 1'b0;
        chk("hold_lat", 64'(lat), 64'd33);
        chk("hold_res", 64'(result), 64'd14);
        @(negedge Clk);
        chk("hold_idle", 64'(busy), 64'd0);

        // Back-to-back: start during FIN
        start_op(MUL, 32'd6, 32'd7);
        wait_done(lat, bc);
        chk("b2b_a", 64'(result), 64'd42);
        op = MOD; op1 = 32'd50; op2 = 32'd8; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("b2b_gap", 64'(busy), 64'd1);
        wait_done(lat, bc);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_b", 64'(result), 64'd2);

        // Reset pulsed mid-CALC
        start_op(DIV, 32'd100, 32'd7);
        repeat (4) @(negedge Clk);
        #2 reset = 1'b0;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_res", 64'(result), 64'd0);
        chk("mr_dbz", 64'(div_by_zero), 64'd0);
        @(negedge Clk);
        reset = 1'b1;
        count_done(40, nd);
        chk("mr_nodone", 64'(nd), 64'd0);
        run("post_rst", MUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd6, 1'b0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
